dot_product_mac: RTL and testbench
==================================

DOT_PRODUCT_MAC -- requirements
Module: dot_product_mac

Interface
REQ-001 Parameter FRACTION_WIDTH, default 15: number of fractional bits of the signed two's-complement fixed-point format.
REQ-002 Parameter BIT_WIDTH, default 32: total width of each operand and of the result.
REQ-003 Parameter VECTOR_SIZE, default 10: number of elements per operand vector; the minimum is 1.
REQ-004 Parameter LANES, default 4: multiplies per cycle; the range is 1..VECTOR_SIZE; BEATS = ceil(VECTOR_SIZE/LANES).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request a new dot product; sampled only when the block is ready.
REQ-008 accumulate  input  1  sampled with start; 1 = add the new dot product to the previous accumulator instead of clearing it.
REQ-009 a_vec  input  BIT_WIDTH x VECTOR_SIZE  first operand vector; captured on an accepted start.
REQ-010 b_vec  input  BIT_WIDTH x VECTOR_SIZE  second operand vector; captured on an accepted start.
REQ-011 busy  output  1  high while an operation is in flight (states RUN and DRAIN).
REQ-012 done  output  1  one-cycle pulse; result and overflow are valid.
REQ-013 result  output  BIT_WIDTH  saturated dot product; held until the next done.
REQ-014 overflow  output  1  sticky per operation; set if any saturation occurred; updated with done.

Function
REQ-015 The FSM SHALL have four states, IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE -> RUN on start.
- RUN -> DRAIN after beat BEATS-1.
- DRAIN -> DONE.
- DONE -> RUN on start, otherwise DONE -> IDLE.
REQ-016 start SHALL be accepted only in IDLE or DONE; start in RUN or DRAIN SHALL be ignored with no side effects.
REQ-017 On acceptance, the block SHALL capture a_vec/b_vec, set beat index 0, clear the accumulator unless accumulate=1, and clear internal overflow unless accumulate=1.
REQ-018 Each RUN cycle SHALL form LANES products of elements beat*LANES+i; lanes with index >= VECTOR_SIZE SHALL contribute exactly 0.
REQ-019 Each product SHALL be the full 2*BIT_WIDTH signed product arithmetic-shifted right by FRACTION_WIDTH (floor); the lane output SHALL be that value saturated to BIT_WIDTH signed, setting overflow on saturation.
REQ-020 Lane products SHALL be registered (pipeline stage 1); the next cycle SHALL add the sum of all lanes to the accumulator (stage 2).
REQ-021 The accumulator width SHALL be ACC_WIDTH = BIT_WIDTH + clog2(VECTOR_SIZE) + 1 and SHALL saturate at its own bounds, setting overflow.
REQ-022 On DONE entry, result SHALL equal the accumulator saturated to BIT_WIDTH signed (0x7FF..F / 0x800..0), setting overflow if clipped.
REQ-023 Latency SHALL be fixed: a start accepted at edge k SHALL give done=1 in the cycle after edge k+BEATS+1, i.e. BEATS+2 cycles; throughput SHALL be one operation per BEATS+2 cycles with back-to-back start in DONE.
REQ-024 If start and a DONE cycle coincide, done SHALL still pulse, and result SHALL hold the finished value while the new operation runs.
REQ-025 The accumulator SHALL be retained across operations so that accumulate=1 chains tiles longer than VECTOR_SIZE.

Reset
REQ-026 While rst_n=0, the block SHALL force state IDLE and busy=0, done=0, result=0, overflow=0, and SHALL clear the accumulator, the pipeline registers and the captured operands, regardless of any operation in progress.
REQ-027 The first edge after rst_n deasserts SHALL be able to accept start.

Structure
REQ-028 Package dot_mac_pkg SHALL hold the state enum typedef, the ACC_WIDTH/BEATS constant functions and the signed saturate function.
REQ-029 One sub-module, fxp_lane_mult (one signed multiply, shift and saturate with an overflow flag), SHALL be instantiated LANES times by a generate loop.

Verification (FRACTION_WIDTH=15, BIT_WIDTH=32, VECTOR_SIZE=10, LANES=4, so BEATS=3; 1.0 = 32768)
REQ-030 All a=32768, b=16384, start pulse -> done exactly 5 cycles later, result=163840 (5.0), overflow=0.
REQ-031 All a=-32768, b=65536 -> result=-655360, overflow=0; a[9]=32768 with all other elements 0 -> result=b[9] (exercises lane padding in the last beat).
REQ-032 All a=b=6553600 (200.0) -> result=0x7FFFFFFF, overflow=1; negating a gives result=0x80000000, overflow=1.
REQ-033 The REQ-030 vectors, then start with accumulate=1 asserted in the DONE cycle -> second done 5 cycles later with result=327680, first result unchanged until then.
REQ-034 start held high during RUN/DRAIN -> no extra operation and no change of captured operands; rst_n pulsed low mid-RUN -> all outputs 0 immediately, no done pulse, and the next start completes normally.

Source files
------------

// File: rtl/dot_mac_pkg.sv
// Shared types and helpers for the fixed-point dot-product MAC: FSM states,
// derived sizing functions and a generic signed saturator.
package dot_mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Saturation helpers work on a wide signed carrier; callers truncate to width.
  localparam int SAT_W = 128;

  function automatic int acc_width(input int bit_width, input int vector_size);
    return bit_width + $clog2(vector_size) + 1;
  endfunction

  function automatic int beats(input int vector_size, input int lanes);
    return (vector_size + lanes - 1) / lanes;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] v,
                                                    input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (v > hi) return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_clip(input logic signed [SAT_W-1:0] v, input int w);
    return sat_s(v, w) != v;
  endfunction

endpackage

// File: rtl/fxp_lane_mult.sv
// One signed fixed-point multiply lane: full-width product, floor shift by the
// fraction width, then saturation back to the operand width with a clip flag.
module fxp_lane_mult
  import dot_mac_pkg::*;
#(
  parameter int BIT_WIDTH      = 32,
  parameter int FRACTION_WIDTH = 15
) (
  input  logic signed [BIT_WIDTH-1:0] i_a,
  input  logic signed [BIT_WIDTH-1:0] i_b,
  output logic signed [BIT_WIDTH-1:0] o_p,
  output logic                        o_ovf
);

  logic signed [2*BIT_WIDTH-1:0] w_a_ext;
  logic signed [2*BIT_WIDTH-1:0] w_b_ext;
  logic signed [2*BIT_WIDTH-1:0] w_full;
  logic signed [2*BIT_WIDTH-1:0] w_shift;

  assign w_a_ext = {{BIT_WIDTH{i_a[BIT_WIDTH-1]}}, i_a};
  assign w_b_ext = {{BIT_WIDTH{i_b[BIT_WIDTH-1]}}, i_b};
  assign w_full  = w_a_ext * w_b_ext;
  assign w_shift = w_full >>> FRACTION_WIDTH;

  assign o_p   = BIT_WIDTH'(sat_s(SAT_W'(w_shift), BIT_WIDTH));
  assign o_ovf = sat_clip(SAT_W'(w_shift), BIT_WIDTH);

endmodule

// File: rtl/dot_product_mac.sv
// Multi-beat signed fixed-point dot product: LANES multiplies per beat, a
// registered product stage, then a saturating accumulator retained across ops.
module dot_product_mac
  import dot_mac_pkg::*;
#(
  parameter int FRACTION_WIDTH = 15,
  parameter int BIT_WIDTH      = 32,
  parameter int VECTOR_SIZE    = 10,
  parameter int LANES          = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               accumulate,
  input  logic [BIT_WIDTH*VECTOR_SIZE-1:0]   a_vec,
  input  logic [BIT_WIDTH*VECTOR_SIZE-1:0]   b_vec,
  output logic                               busy,
  output logic                               done,
  output logic signed [BIT_WIDTH-1:0]        result,
  output logic                               overflow
);

  localparam int ACC_W  = acc_width(BIT_WIDTH, VECTOR_SIZE);
  localparam int BEATS  = beats(VECTOR_SIZE, LANES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = $clog2(BEATS * LANES + 1);
  localparam int SUM_W  = ACC_W + $clog2(LANES) + 2;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [BEAT_W-1:0]           r_beat;
  logic                        w_accept;
  logic                        w_last_beat;

  logic signed [BIT_WIDTH-1:0] r_a [VECTOR_SIZE];
  logic signed [BIT_WIDTH-1:0] r_b [VECTOR_SIZE];

  logic signed [BIT_WIDTH-1:0] w_prod [LANES];
  logic [LANES-1:0]            w_lovf;
  logic signed [BIT_WIDTH-1:0] r_prod_p1 [LANES];
  logic                        r_lovf_p1;
  logic                        r_vld_p1;

  logic signed [ACC_W-1:0]     r_acc;
  logic                        r_ovf;
  logic signed [SUM_W-1:0]     w_sum;
  logic signed [ACC_W-1:0]     w_acc_sat;
  logic                        w_acc_clip;
  logic signed [ACC_W-1:0]     w_acc_nxt;
  logic                        w_ovf_nxt;
  logic signed [BIT_WIDTH-1:0] w_res;
  logic                        w_res_clip;

  assign w_accept    = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_beat) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_beat <= '0;
      else if (r_state == S_RUN && !w_last_beat) r_beat <= r_beat + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < VECTOR_SIZE; e++) begin
        r_a[e] <= '0;
        r_b[e] <= '0;
      end
    end else if (w_accept) begin
      for (int e = 0; e < VECTOR_SIZE; e++) begin
        r_a[e] <= a_vec[e*BIT_WIDTH +: BIT_WIDTH];
        r_b[e] <= b_vec[e*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Lanes past the end of the vector select nothing and so multiply zero.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IDX_W-1:0]            w_idx;
    logic signed [BIT_WIDTH-1:0] w_a;
    logic signed [BIT_WIDTH-1:0] w_b;

    always_comb begin
      w_idx = IDX_W'(r_beat) * IDX_W'(LANES) + IDX_W'(gi);
      w_a   = '0;
      w_b   = '0;
      for (int e = 0; e < VECTOR_SIZE; e++) begin
        if (w_idx == IDX_W'(e)) begin
          w_a = r_a[e];
          w_b = r_b[e];
        end
      end
    end

    fxp_lane_mult #(
      .BIT_WIDTH      (BIT_WIDTH),
      .FRACTION_WIDTH (FRACTION_WIDTH)
    ) u_lane (
      .i_a   (w_a),
      .i_b   (w_b),
      .o_p   (w_prod[gi]),
      .o_ovf (w_lovf[gi])
    );
  end

  // Stage 1: register lane products for the beat currently in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) r_prod_p1[i] <= '0;
      r_lovf_p1 <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) r_prod_p1[i] <= w_prod[i];
      r_lovf_p1 <= |w_lovf;
      r_vld_p1  <= (r_state == S_RUN);
    end
  end

  always_comb begin
    w_sum = SUM_W'(r_acc);
    for (int i = 0; i < LANES; i++) w_sum = w_sum + SUM_W'(r_prod_p1[i]);
    w_acc_sat  = ACC_W'(sat_s(SAT_W'(w_sum), ACC_W));
    w_acc_clip = sat_clip(SAT_W'(w_sum), ACC_W);
    w_acc_nxt  = r_vld_p1 ? w_acc_sat : r_acc;
    w_ovf_nxt  = r_ovf | (r_vld_p1 & (r_lovf_p1 | w_acc_clip));
    w_res      = BIT_WIDTH'(sat_s(SAT_W'(w_acc_nxt), BIT_WIDTH));
    w_res_clip = sat_clip(SAT_W'(w_acc_nxt), BIT_WIDTH);
  end

  // Stage 2: accumulate; the DRAIN edge also publishes result and overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_accept && !accumulate) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_acc_nxt;
        r_ovf <= w_ovf_nxt | ((r_state == S_DRAIN) & w_res_clip);
      end
      if (r_state == S_DRAIN) begin
        result   <= w_res;
        overflow <= w_ovf_nxt | w_res_clip;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// Self-checking bench for dot_product_mac: directed vector table, hand-written
// back-to-back / held-start / mid-run reset sequences and randomized operations.
module tb_dot_product_mac;

  localparam int FW    = 15;
  localparam int BW    = 32;
  localparam int VS    = 10;
  localparam int LANES = 4;
  localparam int N     = BW * VS;
  localparam int BEATS = (VS + LANES - 1) / LANES;
  localparam int ACC_W = BW + $clog2(VS) + 1;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W - 1));
  localparam longint INT_MAX = 64'sd2147483647;
  localparam longint INT_MIN = -64'sd2147483648;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 accumulate;
  logic [N-1:0]         a_vec;
  logic [N-1:0]         b_vec;
  logic                 busy;
  logic                 done;
  logic signed [BW-1:0] result;
  logic                 overflow;

  dot_product_mac #(
    .FRACTION_WIDTH (FW),
    .BIT_WIDTH      (BW),
    .VECTOR_SIZE    (VS),
    .LANES          (LANES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .accumulate (accumulate),
    .a_vec      (a_vec),
    .b_vec      (b_vec),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_err;
  longint      m_acc;
  bit          m_ovf;
  logic [31:0] prev_res;

  typedef struct {
    int a_fill;
    int b_fill;
    bit a_only9;
    bit b_ramp;
    bit accum;
    int exp_res;
    bit exp_ovf;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", nm, got, $signed(got),
               exp, $signed(exp));
    end
  endtask

  function automatic logic [N-1:0] fill_vec(input int v, input bit only9, input bit ramp);
    logic [N-1:0] r;
    int           x;
    for (int i = 0; i < VS; i++) begin
      if (only9) x = (i == VS - 1) ? v : 0;
      else if (ramp) x = v * (i + 1);
      else x = v;
      r[i*BW +: BW] = x;
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_vec(input int mode);
    logic [N-1:0] r;
    int           x;
    int           big;
    big = ($urandom_range(0, 1) == 1) ? 2147483647 : -2147483647;
    for (int i = 0; i < VS; i++) begin
      case (mode)
        0, 1:    x = int'($urandom_range(0, 262143)) - 131072;
        2:       x = int'($urandom_range(0, 33554431)) - 16777216;
        3:       x = int'($urandom());
        default: x = big;
      endcase
      r[i*BW +: BW] = x;
    end
    return r;
  endfunction

  // Reference: element-wise floor products, clipped to 32 bits, summed per beat
  // into a clipped accumulator, final value clipped to 32 bits.
  task automatic model_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit accum,
                          output int er, output bit eo);
    longint s;
    longint p;
    int     ae;
    int     be;
    int     e;
    if (!accum) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    for (int bt = 0; bt < BEATS; bt++) begin
      s = 0;
      for (int l = 0; l < LANES; l++) begin
        e = bt * LANES + l;
        if (e < VS) begin
          ae = a[e*BW +: BW];
          be = b[e*BW +: BW];
          p  = (longint'(ae) * longint'(be)) >>> FW;
          if (p > INT_MAX) begin p = INT_MAX; m_ovf = 1'b1; end
          else if (p < INT_MIN) begin p = INT_MIN; m_ovf = 1'b1; end
          s += p;
        end
      end
      m_acc += s;
      if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_ovf = 1'b1; end
      else if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_ovf = 1'b1; end
    end
    if (m_acc > INT_MAX) begin er = int'(INT_MAX); m_ovf = 1'b1; end
    else if (m_acc < INT_MIN) begin er = int'(INT_MIN); m_ovf = 1'b1; end
    else er = int'(m_acc);
    eo = m_ovf;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or timeout).
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit accum,
                        input bit hold_start, input string nm,
                        output logic [31:0] got_r, output logic got_o);
    int er;
    bit eo;
    int lat;
    bit hold_ok;
    model_op(a, b, accum, er, eo);
    a_vec      = a;
    b_vec      = b;
    accumulate = accum;
    start      = 1'b1;
    lat        = 0;
    hold_ok    = 1'b1;
    @(posedge clk);
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (hold_start) begin
        a_vec = ~a;
        b_vec = ~b;
      end else begin
        start = 1'b0;
      end
      if (lat == 1) check({nm, "_busy"}, 32'(busy), 32'd1);
      if (done) break;
      if (result !== prev_res) hold_ok = 1'b0;
    end
    start = 1'b0;
    got_r = result;
    got_o = overflow;
    check({nm, "_latency"}, 32'(lat), 32'd5);
    check({nm, "_res"}, result, 32'(er));
    check({nm, "_ovf"}, 32'(overflow), 32'(eo));
    check({nm, "_hold"}, 32'(hold_ok), 32'd1);
    prev_res = 32'(er);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] gr;
    logic        go;
    logic [N-1:0] va;
    logic [N-1:0] vb;
    bit          seen;
    int          mode;

    n_chk = 0;
    n_err = 0;
    m_acc = 0;
    m_ovf = 1'b0;
    prev_res = '0;

    tbl[0]  = '{32768, 16384, 1'b0, 1'b0, 1'b0, 163840, 1'b0};
    tbl[1]  = '{-32768, 65536, 1'b0, 1'b0, 1'b0, -655360, 1'b0};
    tbl[2]  = '{32768, 1234, 1'b1, 1'b1, 1'b0, 12340, 1'b0};
    tbl[3]  = '{6553600, 6553600, 1'b0, 1'b0, 1'b0, 32'sh7FFFFFFF, 1'b1};
    tbl[4]  = '{-6553600, 6553600, 1'b0, 1'b0, 1'b0, 32'sh80000000, 1'b1};
    tbl[5]  = '{-1, 1, 1'b0, 1'b0, 1'b0, -10, 1'b0};
    tbl[6]  = '{1, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[7]  = '{2147483647, 2147483647, 1'b0, 1'b0, 1'b0, 32'sh7FFFFFFF, 1'b1};
    tbl[8]  = '{2147483647, 2147483647, 1'b0, 1'b0, 1'b1, 32'sh7FFFFFFF, 1'b1};
    tbl[9]  = '{2147483647, 2147483647, 1'b0, 1'b0, 1'b1, 32'sh7FFFFFFF, 1'b1};
    tbl[10] = '{2147483647, 2147483647, 1'b0, 1'b0, 1'b1, 32'sh7FFFFFFF, 1'b1};
    tbl[11] = '{-32768, 2147483647, 1'b0, 1'b0, 1'b1, 32'sh7FFFFFFF, 1'b1};
    tbl[12] = '{-32768, 2147483647, 1'b0, 1'b0, 1'b1, 32'sh7FFFFFFF, 1'b1};
    tbl[13] = '{-32768, 2147483647, 1'b0, 1'b0, 1'b1, 32'sh7FFFFFFF, 1'b1};
    tbl[14] = '{-32768, 2147483647, 1'b0, 1'b0, 1'b1, 32'sh80000000, 1'b1};
    tbl[15] = '{32768, 16384, 1'b0, 1'b0, 1'b0, 163840, 1'b0};

    rst_n      = 1'b0;
    start      = 1'b0;
    accumulate = 1'b0;
    a_vec      = '0;
    b_vec      = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Start on the very first edge after reset release.
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      va = fill_vec(tbl[i].a_fill, tbl[i].a_only9, 1'b0);
      vb = fill_vec(tbl[i].b_fill, 1'b0, tbl[i].b_ramp);
      run_op(va, vb, tbl[i].accum, 1'b0, $sformatf("tbl%0d", i), gr, go);
      check($sformatf("tbl%0d_const_res", i), gr, 32'(tbl[i].exp_res));
      check($sformatf("tbl%0d_const_ovf", i), 32'(go), 32'(tbl[i].exp_ovf));
      idle(1);
    end

    // Back-to-back: second start lands in the DONE cycle with accumulate=1.
    va = fill_vec(32768, 1'b0, 1'b0);
    vb = fill_vec(16384, 1'b0, 1'b0);
    run_op(va, vb, 1'b0, 1'b0, "b2b_first", gr, go);
    run_op(va, vb, 1'b1, 1'b0, "b2b_second", gr, go);
    check("b2b_const_res", gr, 32'd327680);
    idle(2);

    // start held through RUN/DRAIN with operands changing underneath.
    run_op(va, vb, 1'b0, 1'b1, "held_start", gr, go);
    check("held_const_res", gr, 32'd163840);
    @(negedge clk);
    check("held_after_busy", 32'(busy), 32'd0);
    check("held_after_done", 32'(done), 32'd0);
    idle(1);

    // Leave non-zero result/overflow, then reset in the middle of RUN.
    run_op(fill_vec(6553600, 1'b0, 1'b0), fill_vec(6553600, 1'b0, 1'b0), 1'b0, 1'b0,
           "pre_reset", gr, go);
    idle(1);
    a_vec = fill_vec(-32768, 1'b0, 1'b0);
    b_vec = fill_vec(65536, 1'b0, 1'b0);
    accumulate = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    m_acc = 0;
    m_ovf = 1'b0;
    prev_res = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    // accumulate=1 here proves the accumulator was cleared by reset.
    run_op(va, vb, 1'b1, 1'b0, "post_reset", gr, go);
    check("post_reset_const_res", gr, 32'd163840);

    for (int r = 0; r < 40; r++) begin
      mode = int'($urandom_range(0, 4));
      va = rand_vec(mode);
      vb = rand_vec(mode);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      run_op(va, vb, (r == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0,
             $sformatf("rnd%0d", r), gr, go);
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
